// File: rtl/neurosync_pkg.sv
// Shared definitions for the NeuroSync input conditioner: debounce FSM encoding,
// default timing constants and channel ordering of the niveis bus.
package neurosync_pkg;

    typedef enum logic [1:0] {
        SOLTO,
        CONFIRMA_ALTO,
        PRESSIONADO,
        CONFIRMA_BAIXO
    } db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_RATE     = 5000000;

    localparam int NUM_CHANNELS = 8;
    localparam int CH_JOGAR     = 0;
    localparam int CH_CONFIRMA  = 1;
    localparam int CH_DIREITA   = 2;
    localparam int CH_ESQUERDA  = 3;
    localparam int CH_BOTOES    = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, four-state debounce FSM with a
// saturating stability counter; exposes next-cycle level/press so the top can register them.
module debounce_channel
    import neurosync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press,
    output logic pressed_next,
    output logic level_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync_meta;
    logic          sync_out;
    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;

    // NOTE: non-blocking assignments make both synchronizer flops sample the old
    // values at the same edge; blocking here would collapse the chain to one flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            state     <= SOLTO;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            SOLTO: begin
                if (sync_out) begin
                    state_nxt = CONFIRMA_ALTO;
                    cnt_nxt   = '0;
                end
            end
            CONFIRMA_ALTO: begin
                if (!sync_out) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSIONADO: begin
                if (!sync_out) begin
                    state_nxt = CONFIRMA_BAIXO;
                    cnt_nxt   = '0;
                end
            end
            CONFIRMA_BAIXO: begin
                if (sync_out) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = SOLTO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Only a qualified rise is a press; bouncing back from CONFIRMA_BAIXO is not.
    assign press        = (state == CONFIRMA_ALTO) && (state_nxt == PRESSIONADO);
    assign pressed_next = (state_nxt == PRESSIONADO);
    assign level_next   = (state_nxt == PRESSIONADO) || (state_nxt == CONFIRMA_BAIXO);

endmodule

// File: rtl/neurosync_input_conditioner.sv
// Eight debounced button channels with auto-repeat on direita/esquerda,
// left/right conflict suppression, lowest-index botoes priority and an output enable.
module neurosync_input_conditioner
    import neurosync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       jogar,
    input  logic       confirma,
    input  logic       direita,
    input  logic       esquerda,
    input  logic [3:0] botoes,
    output logic       jogar_det,
    output logic       confirma_det,
    output logic       direita_det,
    output logic       esquerda_det,
    output logic [3:0] botoes_det,
    output logic [7:0] niveis
);

    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] DELAY_CNT = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_CNT  = RW'(REPEAT_RATE);

    logic [NUM_CHANNELS-1:0] raw;
    logic [NUM_CHANNELS-1:0] press;
    logic [NUM_CHANNELS-1:0] pressed_next;
    logic [NUM_CHANNELS-1:0] level_next;
    logic [1:0]              rep_fire;
    logic [1:0]              lr_pulse;
    logic                    lr_block;
    logic [3:0]              bot_press;
    logic [3:0]              bot_sel;

    assign raw = {botoes, esquerda, direita, confirma, jogar};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .raw         (raw[i]),
            .press       (press[i]),
            .pressed_next(pressed_next[i]),
            .level_next  (level_next[i])
        );
    end

    // Held-cycle counter restarts at entry and after every repeat; 'armed' selects
    // the initial delay or the steady repeat period as the next target.
    for (genvar k = 0; k < 2; k++) begin : g_repeat
        localparam int CH = CH_DIREITA + k;

        logic [RW-1:0] cnt;
        logic [RW-1:0] cnt_inc;
        logic [RW-1:0] target;
        logic          armed;

        assign cnt_inc     = cnt + RW'(1);
        assign target      = armed ? RATE_CNT : DELAY_CNT;
        assign rep_fire[k] = pressed_next[CH] && !press[CH] && (cnt_inc == target);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else if (press[CH] || !pressed_next[CH]) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else if (rep_fire[k]) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    assign lr_block  = level_next[CH_DIREITA] & level_next[CH_ESQUERDA];
    assign lr_pulse  = (press[CH_ESQUERDA:CH_DIREITA] | rep_fire) & {2{~lr_block}};
    assign bot_press = press[CH_BOTOES +: 4];
    // Two's-complement trick isolates the lowest set bit.
    assign bot_sel   = bot_press & (~bot_press + 4'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogar_det    <= 1'b0;
            confirma_det <= 1'b0;
            direita_det  <= 1'b0;
            esquerda_det <= 1'b0;
            botoes_det   <= '0;
            niveis       <= '0;
        end else begin
            jogar_det    <= habilita & press[CH_JOGAR];
            confirma_det <= habilita & press[CH_CONFIRMA];
            direita_det  <= habilita & lr_pulse[0];
            esquerda_det <= habilita & lr_pulse[1];
            botoes_det   <= habilita ? bot_sel : 4'd0;
            niveis       <= level_next;
        end
    end

endmodule
